// File: rtl/a2_video_pkg.sv
// Shared Apple II video definitions: fetch FSM states, line geometry and
// the text/hires page base addresses used to locate a scanline in memory.
package a2_video_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } fetch_state_e;

   // Soft-switch state captured at the start of each line fetch.
   typedef struct packed {
      logic text;
      logic mixed;
      logic page2;
      logic hires;
   } video_mode_t;

   localparam int          LINE_WORDS       = 20;      // 40 columns, 2 per word
   localparam logic [15:0] TEXT_PAGE1_BASE  = 16'h0400;
   localparam logic [15:0] TEXT_PAGE2_BASE  = 16'h0800;
   localparam logic [15:0] HIRES_PAGE1_BASE = 16'h2000;
   localparam logic [15:0] HIRES_PAGE2_BASE = 16'h4000;
   localparam logic [7:0]  MIXED_LINE_LIMIT = 8'd160;  // text rows at the bottom in mixed mode
   localparam logic [7:0]  VISIBLE_LINES    = 8'd192;

   // Byte address of column 0 of a scanline, following the Apple II
   // interleaved memory map for text (8-line character rows) and hires.
   function automatic logic [15:0] line_base(input logic [7:0] line, input video_mode_t mode);
      logic [4:0]  row;
      logic [15:0] base;
      row = line[7:3];
      if (mode.text || (mode.mixed && (line >= MIXED_LINE_LIMIT)) || !mode.hires) begin
         base = (mode.page2 ? TEXT_PAGE2_BASE : TEXT_PAGE1_BASE)
              + {6'd0, row[2:0], 7'd0}
              + ({14'd0, row[4:3]} * 16'd40);
      end else begin
         base = (mode.page2 ? HIRES_PAGE2_BASE : HIRES_PAGE1_BASE)
              + {3'd0, line[2:0], 10'd0}
              + {6'd0, line[5:3], 7'd0}
              + ({14'd0, line[7:6]} * 16'd40);
      end
      return base;
   endfunction

endpackage

// File: rtl/sdpram32.sv
// Simple dual-port 32-bit RAM: one write port, one registered read port.
module sdpram32 #(
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [31:0]           wdata_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [31:0]           rdata_o
);

   logic [31:0] mem_q [2**ADDR_WIDTH];

   // Write when enabled; read data appears one cycle after the address.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/video_line_fetcher.sv
// Fetches one Apple II scanline (20 x 32-bit words) into a ping-pong line
// buffer while the display side reads the previously completed line.
// Memory handshake: video_rd_o is a one-cycle request; the matching word is
// accepted in any later WAIT cycle where video_valid_i is high. If no data
// arrives within TIMEOUT_CYCLES WAIT cycles the word is stored as zero.
module video_line_fetcher
   import a2_video_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk_logic,
   input  logic        reset,
   input  logic        line_start_i,
   input  logic [7:0]  line_i,
   input  logic        text_mode_i,
   input  logic        mixed_mode_i,
   input  logic        page2_i,
   input  logic        hires_mode_i,
   output logic [15:0] video_address_o,
   output logic        video_bank_o,
   output logic        video_rd_o,
   input  logic [31:0] video_data_i,
   input  logic        video_valid_i,
   input  logic [5:0]  rd_col_i,
   output logic [7:0]  main_byte_o,
   output logic [7:0]  aux_byte_o,
   output logic        fetch_done_o,
   output logic        timeout_err_o,
   output logic [1:0]  state_dbg_o
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   fetch_state_e state_q, state_d;
   logic [4:0]   count_q, count_d;
   logic [TW-1:0] timer_q, timer_d;

   logic [7:0]   line_q;
   video_mode_t  mode_q;
   logic         swap_q;       // selects the display buffer; fill is the other one
   logic         complete_q;   // fill buffer holds a whole line
   logic         timeout_err_q;
   logic         rd_ok_q;
   logic         rd_odd_q;

   logic         start_ok;
   logic         timed_out;
   logic         word_end;
   logic         last_word;
   logic [15:0]  base;
   logic         ram_we;
   logic [31:0]  ram_wdata;
   logic [31:0]  ram_rdata;

   assign start_ok  = line_start_i && (line_i < VISIBLE_LINES);
   assign timed_out = !video_valid_i && (timer_q == TW'(TIMEOUT_CYCLES - 1));
   assign word_end  = (state_q == ST_WAIT) && (video_valid_i || timed_out) && !start_ok;
   assign last_word = (count_q == 5'(LINE_WORDS - 1));
   assign base      = line_base(line_q, mode_q);

   // State register with counters.
   always_ff @(posedge clk_logic) begin
      if (reset) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         timer_q <= timer_d;
      end
   end

   // Next state: a new line_start restarts from any state and beats read data.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      timer_d = timer_q;
      if (start_ok) begin
         state_d = ST_ISSUE;
         count_d = '0;
         timer_d = '0;
      end else begin
         case (state_q)
            ST_IDLE:  state_d = ST_IDLE;
            ST_ISSUE: begin
               state_d = ST_WAIT;
               timer_d = '0;
            end
            ST_WAIT: begin
               if (video_valid_i || timed_out) begin
                  if (last_word) begin
                     state_d = ST_DONE;
                  end else begin
                     count_d = count_q + 5'd1;
                     state_d = ST_ISSUE;
                  end
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Outputs decoded from the current state.
   always_comb begin
      video_rd_o      = (state_q == ST_ISSUE);
      video_address_o = '0;
      if ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) begin
         video_address_o = base + {10'd0, count_q, 1'b0};
      end
      fetch_done_o = (state_q == ST_DONE) && !start_ok;
      ram_we       = word_end;
      ram_wdata    = video_valid_i ? video_data_i : 32'd0;
   end

   // Line latch, buffer swap/complete tracking, sticky error, read pipeline.
   always_ff @(posedge clk_logic) begin
      if (reset) begin
         line_q        <= '0;
         mode_q        <= '0;
         swap_q        <= 1'b0;
         complete_q    <= 1'b0;
         timeout_err_q <= 1'b0;
         rd_ok_q       <= 1'b0;
         rd_odd_q      <= 1'b0;
      end else begin
         if (start_ok) begin
            line_q     <= line_i;
            mode_q     <= {text_mode_i, mixed_mode_i, page2_i, hires_mode_i};
            complete_q <= 1'b0;
            if (complete_q) begin
               swap_q <= ~swap_q;
            end
         end else if (state_q == ST_DONE) begin
            complete_q <= 1'b1;
         end
         if (word_end && !video_valid_i) begin
            timeout_err_q <= 1'b1;
         end
         rd_ok_q  <= (rd_col_i < 6'd40);
         rd_odd_q <= rd_col_i[0];
      end
   end

   sdpram32 #(
      .ADDR_WIDTH(6)
   ) u_line_ram (
      .clk_i   (clk_logic),
      .we_i    (ram_we),
      .waddr_i ({~swap_q, count_q}),
      .wdata_i (ram_wdata),
      .raddr_i ({swap_q, rd_col_i[5:1]}),
      .rdata_o (ram_rdata)
   );

   // Lane order {aux odd, main odd, aux even, main even}.
   assign main_byte_o   = !rd_ok_q ? 8'd0 : (rd_odd_q ? ram_rdata[23:16] : ram_rdata[7:0]);
   assign aux_byte_o    = !rd_ok_q ? 8'd0 : (rd_odd_q ? ram_rdata[31:24] : ram_rdata[15:8]);
   assign timeout_err_o = timeout_err_q;
   assign video_bank_o  = 1'b0;
   assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_video_line_fetcher.sv
// Bench for video_line_fetcher: a memory responder answers read requests,
// a monitor scores every request address against an expected queue.
module tb_video_line_fetcher;

   logic        clk_logic = 1'b0;
   logic        reset;
   logic        line_start_i;
   logic [7:0]  line_i;
   logic        text_mode_i, mixed_mode_i, page2_i, hires_mode_i;
   logic [15:0] video_address_o;
   logic        video_bank_o;
   logic        video_rd_o;
   logic [31:0] video_data_i;
   logic        video_valid_i;
   logic [5:0]  rd_col_i;
   logic [7:0]  main_byte_o, aux_byte_o;
   logic        fetch_done_o;
   logic        timeout_err_o;
   logic [1:0]  state_dbg_o;

   int pass_cnt  = 0;
   int check_cnt = 0;

   logic [15:0] exp_q[$];
   int          due_q[$];
   logic [15:0] rsp_addr_q[$];
   int          cyc = 0;
   int          last_rd_cyc = 0;
   int          done_cnt = 0;
   logic [15:0] withhold_addr = 16'hFFFF;
   logic [15:0] gap_addr = 16'hFFFF;

   video_line_fetcher #(.TIMEOUT_CYCLES(16)) dut (
      .clk_logic       (clk_logic),
      .reset           (reset),
      .line_start_i    (line_start_i),
      .line_i          (line_i),
      .text_mode_i     (text_mode_i),
      .mixed_mode_i    (mixed_mode_i),
      .page2_i         (page2_i),
      .hires_mode_i    (hires_mode_i),
      .video_address_o (video_address_o),
      .video_bank_o    (video_bank_o),
      .video_rd_o      (video_rd_o),
      .video_data_i    (video_data_i),
      .video_valid_i   (video_valid_i),
      .rd_col_i        (rd_col_i),
      .main_byte_o     (main_byte_o),
      .aux_byte_o      (aux_byte_o),
      .fetch_done_o    (fetch_done_o),
      .timeout_err_o   (timeout_err_o),
      .state_dbg_o     (state_dbg_o)
   );

   // clock / watchdog
   always #5 clk_logic = ~clk_logic;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, check_cnt);
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] data_for(input logic [15:0] a);
      return {a ^ 16'hA5A5, a};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // memory responder: answers each request 3 cycles later unless withheld
   initial begin
      video_valid_i = 1'b0;
      video_data_i  = '0;
      forever begin
         @(posedge clk_logic);
         cyc++;
         #1;
         if (due_q.size() > 0 && due_q[0] <= cyc) begin
            video_valid_i = 1'b1;
            video_data_i  = data_for(rsp_addr_q[0]);
            void'(due_q.pop_front());
            void'(rsp_addr_q.pop_front());
         end else begin
            video_valid_i = 1'b0;
            video_data_i  = '0;
         end
      end
   end

   // monitor / scoreboard
   initial begin
      logic [15:0] e;
      forever begin
         @(negedge clk_logic);
         if (video_rd_o) begin
            if (exp_q.size() == 0) begin
               check_cnt++;
               $display("FAIL unexpected_rd: got address 0x%0h with no request expected", video_address_o);
            end else begin
               e = exp_q.pop_front();
               chk("rd_addr", {16'd0, video_address_o}, {16'd0, e});
            end
            if (video_address_o == gap_addr) chk("timeout_gap", cyc - last_rd_cyc, 17);
            last_rd_cyc = cyc;
            if (video_address_o != withhold_addr) begin
               due_q.push_back(cyc + 3);
               rsp_addr_q.push_back(video_address_o);
            end
         end
         if (fetch_done_o) done_cnt++;
      end
   end

   // driver tasks
   task automatic push_line(input logic [15:0] base, input int nwords);
      for (int i = 0; i < nwords; i++) exp_q.push_back(base + 16'(2 * i));
   endtask

   task automatic set_line(input logic [7:0] line, input logic t, input logic m, input logic p2, input logic h);
      line_i = line; text_mode_i = t; mixed_mode_i = m; page2_i = p2; hires_mode_i = h;
   endtask

   task automatic pulse_start();
      line_start_i = 1'b1;
      @(posedge clk_logic); #1;
      line_start_i = 1'b0;
   endtask

   task automatic start_line(input logic [7:0] line, input logic t, input logic m, input logic p2,
                             input logic h, input logic [15:0] base, input int nwords);
      @(posedge clk_logic); #1;
      push_line(base, nwords);
      set_line(line, t, m, p2, h);
      pulse_start();
   endtask

   task automatic wait_done(input int target, input string name);
      int n = 0;
      while (done_cnt < target && n < 600) begin
         @(negedge clk_logic);
         n++;
      end
      @(negedge clk_logic);
      chk(name, done_cnt, target);
   endtask

   task automatic wait_rd(input logic [15:0] addr);
      int n = 0;
      do begin
         @(negedge clk_logic);
         n++;
      end while (!(video_rd_o && video_address_o == addr) && n < 600);
      if (n >= 600) begin
         check_cnt++;
         $display("FAIL wait_rd: no request for address 0x%0h within 600 cycles", addr);
      end
   endtask

   task automatic read_col(input logic [5:0] col, input logic [7:0] em, input logic [7:0] ea, input string name);
      @(posedge clk_logic); #1;
      rd_col_i = col;
      @(posedge clk_logic); #1;
      chk({name, "_main"}, main_byte_o, em);
      chk({name, "_aux"}, aux_byte_o, ea);
   endtask

   task automatic check_idle(input string name);
      chk({name, "_state"}, state_dbg_o, 2'd0);
      chk({name, "_rd"}, video_rd_o, 1'b0);
      chk({name, "_addr"}, video_address_o, 16'h0000);
      chk({name, "_bank"}, video_bank_o, 1'b0);
      chk({name, "_done"}, fetch_done_o, 1'b0);
      chk({name, "_err"}, timeout_err_o, 1'b0);
      chk({name, "_main"}, main_byte_o, 8'h00);
      chk({name, "_aux"}, aux_byte_o, 8'h00);
   endtask

   initial begin
      reset = 1'b1;
      line_start_i = 1'b0;
      set_line(8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      rd_col_i = 6'd63;
      repeat (3) @(posedge clk_logic);
      @(negedge clk_logic);
      check_idle("reset");
      @(posedge clk_logic); #1;
      reset = 1'b0;

      // line 192 is off-screen and must be ignored
      @(posedge clk_logic); #1;
      set_line(8'd192, 1'b1, 1'b0, 1'b0, 1'b0);
      pulse_start();
      repeat (5) @(negedge clk_logic);
      chk("ignore_192_state", state_dbg_o, 2'd0);

      // text line 0, page 1: 0x0400 .. 0x0426
      start_line(8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0400, 20);
      wait_done(1, "text0_done");

      // hires line 65, page 2 (mixed set, but line < 160): 0x4428 .. 0x444E
      start_line(8'd65, 1'b0, 1'b1, 1'b1, 1'b1, 16'h4428, 20);
      read_col(6'd0, 8'h00, 8'h04, "text0_col0");
      read_col(6'd1, 8'hA5, 8'hA1, "text0_col1");
      read_col(6'd38, 8'h26, 8'h04, "text0_col38");
      read_col(6'd39, 8'h83, 8'hA1, "text0_col39");
      read_col(6'd40, 8'h00, 8'h00, "col40_zero");
      read_col(6'd63, 8'h00, 8'h00, "col63_zero");
      wait_done(2, "hires65_done");

      // hires + mixed, line 170, page 1 -> text base 0x06D0
      start_line(8'd170, 1'b0, 1'b1, 1'b0, 1'b1, 16'h06D0, 20);
      read_col(6'd2, 8'h2A, 8'h44, "hires65_col2");
      read_col(6'd3, 8'h8F, 8'hE1, "hires65_col3");
      wait_done(3, "mixed170_done");
      chk("no_err_yet", timeout_err_o, 1'b0);

      // line 8 with hires off -> text base 0x0480; word 5 (0x048A) withheld
      withhold_addr = 16'h048A;
      gap_addr      = 16'h048C;
      start_line(8'd8, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0480, 20);
      wait_done(4, "timeout_done");
      chk("timeout_err_set", timeout_err_o, 1'b1);
      withhold_addr = 16'hFFFF;
      gap_addr      = 16'hFFFF;

      // abort: line 16 (0x0500) restarted at word 10 by line 24 (0x0580)
      start_line(8'd16, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0500, 11);
      read_col(6'd8, 8'h88, 8'h04, "line8_col8");
      read_col(6'd10, 8'h00, 8'h00, "line8_col10_timeout");
      read_col(6'd11, 8'h00, 8'h00, "line8_col11_timeout");
      wait_rd(16'h0514);
      repeat (3) @(posedge clk_logic);
      #1;
      push_line(16'h0580, 20);
      set_line(8'd24, 1'b1, 1'b0, 1'b0, 1'b0);
      pulse_start();
      read_col(6'd8, 8'h88, 8'h04, "abort_keep_col8");
      read_col(6'd10, 8'h00, 8'h00, "abort_keep_col10");
      wait_done(5, "abort_done_count");
      chk("abort_queue_empty", exp_q.size(), 0);

      // reset while waiting for word 2 of line 32 (0x0600)
      start_line(8'd32, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0600, 20);
      wait_rd(16'h0604);
      rd_col_i = 6'd5;
      @(posedge clk_logic); #1;
      reset = 1'b1;
      @(posedge clk_logic); #1;
      reset = 1'b0;
      exp_q.delete();
      @(negedge clk_logic);
      check_idle("mid_reset");
      repeat (8) @(posedge clk_logic);
      start_line(8'd40, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0680, 20);
      wait_done(6, "after_reset_done");
      chk("final_queue_empty", exp_q.size(), 0);

      repeat (4) @(posedge clk_logic);
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
